// File: rtl/ddr2_pkg.sv
// Shared DDR2 user-port widths, arbiter state encoding and a small one-hot helper.
package ddr2_pkg;

    localparam int DDR2_AW       = 31;
    localparam int DDR2_DW       = 256;
    localparam int DDR2_BW       = 128;
    localparam int DDR2_MW       = 32;
    localparam int BEATS_PER_CMD = 2;

    typedef enum logic [1:0] {
        S_IDLE = 2'b01,
        S_BUSY = 2'b10
    } arb_state_t;

    // Port indices are at most 3 bits wide because the arbiter serves up to 8 requesters.
    function automatic logic [7:0] port_onehot(input logic [2:0] idx);
        port_onehot = 8'b1 << idx;
    endfunction

endpackage

// File: rtl/ddr2_arbiter_if.sv
// User-side requester bundle plus the downstream DDR2 converter port, as seen by the arbiter.
interface ddr2_arbiter_if #(
    parameter int NUM_PORTS = 4
);
    import ddr2_pkg::*;

    logic [NUM_PORTS-1:0]         p_req;
    logic [NUM_PORTS-1:0]         p_ack;
    logic [NUM_PORTS*DDR2_AW-1:0] p_addr;
    logic [NUM_PORTS-1:0]         p_read;
    logic [NUM_PORTS*DDR2_DW-1:0] p_data;
    logic [NUM_PORTS*DDR2_MW-1:0] p_mask;
    logic [NUM_PORTS-1:0]         p_valid;
    logic [DDR2_BW-1:0]           p_rdata;

    logic                         m_req;
    logic                         m_ack;
    logic [DDR2_AW-1:0]           m_addr;
    logic                         m_read;
    logic [DDR2_DW-1:0]           m_data;
    logic [DDR2_MW-1:0]           m_mask;
    logic                         m_valid;
    logic [DDR2_BW-1:0]           m_rdata;

    // The arbiter is the master: it drives acks/read beats upward and commands downward.
    modport master (
        input  p_req, p_addr, p_read, p_data, p_mask, m_ack, m_valid, m_rdata,
        output p_ack, p_valid, p_rdata, m_req, m_addr, m_read, m_data, m_mask
    );

    modport slave (
        output p_req, p_addr, p_read, p_data, p_mask, m_ack, m_valid, m_rdata,
        input  p_ack, p_valid, p_rdata, m_req, m_addr, m_read, m_data, m_mask
    );

endinterface

// File: rtl/ddr2_arb_tag_fifo.sv
// In-order FIFO of requester indices for reads still waiting on their return beats.
module ddr2_arb_tag_fifo #(
    parameter int PW        = 2,
    parameter int TAG_DEPTH = 16
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          push,
    input  logic [PW-1:0] push_tag,
    input  logic          pop,
    output logic          full,
    output logic          empty,
    output logic [PW-1:0] head
);

    localparam int AW = $clog2(TAG_DEPTH);

    logic [PW-1:0] mem [TAG_DEPTH];
    logic [AW:0]   wr_ptr;
    logic [AW:0]   rd_ptr;
    logic          do_push;
    logic          do_pop;

    // Pointers carry one extra wrap bit so full and empty can be told apart.
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (do_push) begin
            mem[wr_ptr[AW-1:0]] <= push_tag;
        end
    end

endmodule

// File: rtl/ddr2_arbiter.sv
// Round-robin arbiter sharing one DDR2 converter port among NUM_PORTS requesters,
// steering two-beat read returns back to the issuing port through an in-order tag FIFO.
module ddr2_arbiter
    import ddr2_pkg::*;
#(
    parameter int NUM_PORTS = 4,
    parameter int PW        = 2,
    parameter int MAX_BURST = 8,
    parameter int TAG_DEPTH = 16
) (
    input  logic           CLK,
    input  logic           RST,
    ddr2_arbiter_if.master bus,
    output logic           err_orphan
);

    localparam int CW  = $clog2(MAX_BURST + 1);
    localparam int BTW = (BEATS_PER_CMD > 1) ? $clog2(BEATS_PER_CMD) : 1;

    arb_state_t     state;
    arb_state_t     state_nxt;
    logic [PW-1:0]  grant;
    logic [PW-1:0]  grant_nxt;
    logic [PW-1:0]  last;
    logic [PW-1:0]  last_nxt;
    logic [CW-1:0]  cnt;
    logic [CW-1:0]  cnt_nxt;
    logic [BTW-1:0] beat;

    logic           any_req;
    logic [PW-1:0]  rr_pick;
    logic           req_int;
    logic           ack;
    logic           push;
    logic           pop;
    logic           tag_full;
    logic           tag_empty;
    logic [PW-1:0]  tag_head;
    logic [7:0]     grant_oh;
    logic [7:0]     head_oh;

    // Nearest requester after 'from' wins; 'from' itself is checked last.
    function automatic logic [PW-1:0] rr_next(input logic [NUM_PORTS-1:0] req,
                                             input logic [PW-1:0]        from);
        logic [PW-1:0] pick;
        int            idx;
        pick = from;
        for (int i = NUM_PORTS; i >= 1; i--) begin
            idx = (int'(from) + i) % NUM_PORTS;
            if (req[idx]) begin
                pick = PW'(idx);
            end
        end
        return pick;
    endfunction

    assign any_req = |bus.p_req;
    assign rr_pick = rr_next(bus.p_req, last);

    // A granted read is held off while every tag slot is in use; writes never need a tag.
    assign req_int = (state == S_BUSY) && bus.p_req[grant] && !(bus.p_read[grant] && tag_full);
    assign ack     = req_int && bus.m_ack;
    assign push    = ack && bus.p_read[grant];
    assign pop     = bus.m_valid && (beat == BTW'(BEATS_PER_CMD - 1));

    assign grant_oh = port_onehot(3'(grant));
    assign head_oh  = port_onehot(3'(tag_head));

    assign bus.m_req   = req_int;
    assign bus.m_addr  = bus.p_addr[DDR2_AW*grant +: DDR2_AW];
    assign bus.m_read  = bus.p_read[grant];
    assign bus.m_data  = bus.p_data[DDR2_DW*grant +: DDR2_DW];
    assign bus.m_mask  = bus.p_mask[DDR2_MW*grant +: DDR2_MW];
    assign bus.p_ack   = ack ? grant_oh[NUM_PORTS-1:0] : '0;
    assign bus.p_rdata = bus.m_rdata;
    assign bus.p_valid = (bus.m_valid && !tag_empty) ? head_oh[NUM_PORTS-1:0] : '0;

    always_comb begin
        state_nxt = state;
        grant_nxt = grant;
        last_nxt  = last;
        cnt_nxt   = cnt;
        unique case (state)
            S_IDLE: begin
                if (any_req) begin
                    grant_nxt = rr_pick;
                    cnt_nxt   = '0;
                    state_nxt = S_BUSY;
                end
            end
            S_BUSY: begin
                if (ack) begin
                    cnt_nxt = cnt + 1'b1;
                end
                if (!bus.p_req[grant] || (ack && (cnt == CW'(MAX_BURST - 1)))) begin
                    state_nxt = S_IDLE;
                    last_nxt  = grant;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state <= S_IDLE;
            grant <= '0;
            last  <= PW'(NUM_PORTS - 1);
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            grant <= grant_nxt;
            last  <= last_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Beat position advances on every returned beat, including ones with no owner.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            beat       <= '0;
            err_orphan <= 1'b0;
        end else if (bus.m_valid) begin
            beat <= (beat == BTW'(BEATS_PER_CMD - 1)) ? '0 : beat + 1'b1;
            if (tag_empty) begin
                err_orphan <= 1'b1;
            end
        end
    end

    ddr2_arb_tag_fifo #(
        .PW        (PW),
        .TAG_DEPTH (TAG_DEPTH)
    ) u_tag_fifo (
        .CLK      (CLK),
        .RST      (RST),
        .push     (push),
        .push_tag (grant),
        .pop      (pop),
        .full     (tag_full),
        .empty    (tag_empty),
        .head     (tag_head)
    );

endmodule
